// File: rtl/send_issue.sv
// SendU instruction-byte issuer: queues transfer requests and splits each into
// register chunks that never wrap 7->0. Optional byte counter under SENDU_ISSUE_STATS_EN.
module send_issue #(
  parameter int QDEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  output logic       io_din_input_ready,
  input  logic       io_din_input_valid,
  input  logic [1:0] io_din_dest_pe,
  input  logic [2:0] io_din_reg_start_addr,
  input  logic [4:0] io_din_count,
  input  logic       io_dout_output_ready,
  output logic       io_dout_output_valid,
  output logic [7:0] io_dout_output_bits,
`ifdef SENDU_ISSUE_STATS_EN
  output logic [15:0] io_stat_bytes,
`endif
  output logic       io_busy
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = QDEPTH[AW:0];

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  // Queue entry layout: {dest[9:8], addr[7:5], count[4:0]}
  logic [9:0]    q_mem_r [QDEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   cnt_r;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [1:0] dest_r;
  logic [2:0] cur_addr_r;
  logic [4:0] rem_r;
  logic       out_valid_r;
  logic [7:0] out_bits_r;

  logic       push_s;
  logic       pop_s;
  logic       load_s;
  logic       slot_free_s;
  logic [9:0] head_s;
  logic [3:0] avail_s;
  logic [3:0] chunk_s;
  logic [3:0] len_s;
  logic       last_s;

  assign head_s      = q_mem_r[rd_ptr_r];
  assign push_s      = io_din_input_valid && io_din_input_ready;
  assign slot_free_s = !out_valid_r || io_dout_output_ready;

  // Chunk size: remaining registers, capped at the distance to register 7.
  assign avail_s = 4'd8 - {1'b0, cur_addr_r};
  assign chunk_s = ({1'b0, avail_s} < rem_r) ? avail_s : rem_r[3:0];
  assign len_s   = chunk_s - 4'd1;
  assign last_s  = (rem_r == {1'b0, chunk_s});

  // Request queue storage and pointers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_mem_r[i] <= 10'd0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_s) begin
        q_mem_r[wr_ptr_r] <= {io_din_dest_pe, io_din_reg_start_addr, io_din_count};
        wr_ptr_r          <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + {{AW{1'b0}}, 1'b1};
        2'b01:   cnt_r <= cnt_r - {{AW{1'b0}}, 1'b1};
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: zero-count requests are popped without entering ACTIVE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if ((cnt_r != '0) && (head_s[4:0] != 5'd0)) begin
          state_nxt_s = ACTIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACTIVE: begin
        if (slot_free_s && last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACTIVE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: pop the queue head when idle, load a byte when the slot frees
  always_comb begin
    pop_s  = 1'b0;
    load_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cnt_r != '0) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      ACTIVE: begin
        if (slot_free_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        pop_s  = 1'b0;
        load_s = 1'b0;
      end
    endcase
  end

  // Working request registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dest_r     <= 2'd0;
      cur_addr_r <= 3'd0;
      rem_r      <= 5'd0;
    end else if (pop_s) begin
      dest_r     <= head_s[9:8];
      cur_addr_r <= head_s[7:5];
      rem_r      <= head_s[4:0];
    end else if (load_s) begin
      dest_r     <= dest_r;
      cur_addr_r <= cur_addr_r + chunk_s[2:0];
      rem_r      <= rem_r - {1'b0, chunk_s};
    end else begin
      dest_r     <= dest_r;
      cur_addr_r <= cur_addr_r;
      rem_r      <= rem_r;
    end
  end

  // Output byte register: bits hold while stalled, valid drops after an unrefilled transfer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_bits_r  <= 8'd0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_bits_r  <= {len_s[2:0], cur_addr_r, dest_r};
    end else if (io_dout_output_ready) begin
      out_valid_r <= 1'b0;
      out_bits_r  <= out_bits_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_bits_r  <= out_bits_r;
    end
  end

`ifdef SENDU_ISSUE_STATS_EN
  logic [15:0] stat_bytes_r;

  // Count of accepted output bytes, free-running with natural wrap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_bytes_r <= 16'd0;
    end else if (out_valid_r && io_dout_output_ready) begin
      stat_bytes_r <= stat_bytes_r + 16'd1;
    end else begin
      stat_bytes_r <= stat_bytes_r;
    end
  end

  assign io_stat_bytes = stat_bytes_r;
`endif

  assign io_din_input_ready   = (cnt_r != FULL_CNT);
  assign io_dout_output_valid = out_valid_r;
  assign io_dout_output_bits  = out_bits_r;
  assign io_busy              = (cnt_r != '0) || (state_r == ACTIVE) || out_valid_r;

endmodule

// File: tb/tb_send_issue.sv
// Scoreboard bench for send_issue: stimulus pushes expected bytes, a negedge
// monitor pops and compares on every accepted output byte.
module tb_send_issue;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       io_din_input_ready;
  logic       io_din_input_valid = 1'b0;
  logic [1:0] io_din_dest_pe = 2'd0;
  logic [2:0] io_din_reg_start_addr = 3'd0;
  logic [4:0] io_din_count = 5'd0;
  logic       io_dout_output_ready = 1'b1;
  logic       io_dout_output_valid;
  logic [7:0] io_dout_output_bits;
  logic       io_busy;
`ifdef SENDU_ISSUE_STATS_EN
  logic [15:0] io_stat_bytes;
`endif

  send_issue #(.QDEPTH(2)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_din_input_ready    (io_din_input_ready),
    .io_din_input_valid    (io_din_input_valid),
    .io_din_dest_pe        (io_din_dest_pe),
    .io_din_reg_start_addr (io_din_reg_start_addr),
    .io_din_count          (io_din_count),
    .io_dout_output_ready  (io_dout_output_ready),
    .io_dout_output_valid  (io_dout_output_valid),
    .io_dout_output_bits   (io_dout_output_bits),
`ifdef SENDU_ISSUE_STATS_EN
    .io_stat_bytes         (io_stat_bytes),
`endif
    .io_busy               (io_busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfer_n = 0;
  int rdy_mode = 1;  // 0 low, 1 high, 2 toggle
  logic [7:0] exp_q[$];
  int xfer_cyc_q[$];
  logic prev_stall = 1'b0;
  logic [7:0] prev_bits = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ready driver: a single process owns the output-ready input
  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       io_dout_output_ready = 1'b0;
      1:       io_dout_output_ready = 1'b1;
      default: io_dout_output_ready = ~io_dout_output_ready;
    endcase
  end

  // monitor: compare accepted bytes against the scoreboard and check stall stability
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      prev_stall = 1'b0;
      xfer_n     = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, io_dout_output_valid}, 32'd1);
        chk("hold_bits", {24'd0, io_dout_output_bits}, {24'd0, prev_bits});
      end
      if (io_dout_output_valid && io_dout_output_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", io_dout_output_bits);
        end else begin
          chk("byte", {24'd0, io_dout_output_bits}, {24'd0, exp_q.pop_front()});
        end
        xfer_cyc_q.push_back(cyc);
        xfer_n++;
      end
      prev_stall = io_dout_output_valid && !io_dout_output_ready;
      prev_bits  = io_dout_output_bits;
    end
  end

  task automatic push(input logic [1:0] d, input logic [2:0] a, input logic [4:0] c);
    int t = 0;
    io_din_dest_pe        = d;
    io_din_reg_start_addr = a;
    io_din_count          = c;
    io_din_input_valid    = 1'b1;
    @(negedge clock);
    while (!io_din_input_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!io_din_input_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: input_ready 0 expected 1");
    end
    @(posedge clock);
    #1;
    io_din_input_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    @(negedge clock);
    while ((exp_q.size() != 0 || io_busy) && t < 500) begin
      @(negedge clock);
      t++;
    end
    chk({name, "_left"}, exp_q.size(), 32'd0);
    chk({name, "_busy"}, {31'd0, io_busy}, 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", {31'd0, io_dout_output_valid}, 32'd0);
    chk("rst_bits", {24'd0, io_dout_output_bits}, 32'd0);
    chk("rst_busy", {31'd0, io_busy}, 32'd0);
    chk("rst_ready", {31'd0, io_din_input_ready}, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // 1: single chunk, latency of three cycles
    exp_q.push_back(8'h46);
    push(2'd2, 3'd1, 5'd3);
    @(negedge clock);
    chk("lat_n1", {31'd0, io_dout_output_valid}, 32'd0);
    @(negedge clock);
    chk("lat_n2", {31'd0, io_dout_output_valid}, 32'd0);
    @(negedge clock);
    chk("lat_n3", {31'd0, io_dout_output_valid}, 32'd1);
    drain("t1");

    // 2: wrap split into two chunks, back-to-back
    xfer_cyc_q.delete();
    exp_q.push_back(8'h39);
    exp_q.push_back(8'h41);
    push(2'd1, 3'd6, 5'd5);
    drain("t2");
    chk("t2_n", xfer_cyc_q.size(), 32'd2);
    if (xfer_cyc_q.size() == 2) chk("t2_b2b", xfer_cyc_q[1] - xfer_cyc_q[0], 32'd1);

    // 3: long request then a zero-count request
    exp_q.push_back(8'hE3);
    exp_q.push_back(8'hE3);
    exp_q.push_back(8'h63);
    push(2'd3, 3'd0, 5'd20);
    push(2'd0, 3'd0, 5'd0);
    drain("t3");

    // one-bubble gap between consecutive requests
    xfer_cyc_q.delete();
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'h01);
    push(2'd0, 3'd0, 5'd16);
    push(2'd1, 3'd0, 5'd1);
    drain("gap");
    chk("gap_n", xfer_cyc_q.size(), 32'd3);
    if (xfer_cyc_q.size() == 3) begin
      chk("gap_b2b", xfer_cyc_q[1] - xfer_cyc_q[0], 32'd1);
      chk("gap_bubble", xfer_cyc_q[2] - xfer_cyc_q[1], 32'd2);
    end

    // 4: ready toggling
    rdy_mode = 2;
    exp_q.push_back(8'h46);
    exp_q.push_back(8'h39);
    exp_q.push_back(8'h41);
    push(2'd2, 3'd1, 5'd3);
    push(2'd1, 3'd6, 5'd5);
    drain("t4");

    // 5: back-pressure fills queue
    rdy_mode = 0;
    repeat (2) @(posedge clock);
    #1;
    exp_q.push_back(8'h09);
    exp_q.push_back(8'h2E);
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h54);
    push(2'd1, 3'd2, 5'd1);
    push(2'd2, 3'd3, 5'd2);
    push(2'd3, 3'd4, 5'd1);
    push(2'd0, 3'd5, 5'd3);
    repeat (3) @(negedge clock);
    chk("t5_full", {31'd0, io_din_input_ready}, 32'd0);
    chk("t5_stall_valid", {31'd0, io_dout_output_valid}, 32'd1);
    rdy_mode = 1;
    repeat (3) @(negedge clock);
    chk("t5_recover", {31'd0, io_din_input_ready}, 32'd1);
    drain("t5");

    // 6: reset mid-request after the first byte
    exp_q.push_back(8'h39);
    exp_q.push_back(8'h41);
    t = xfer_n;
    push(2'd1, 3'd6, 5'd5);
    while (xfer_n == t && t < 1000) begin
      @(negedge clock);
      if (xfer_n == t && cyc > 5000) t = 1000;
    end
    chk("t6_first", xfer_n - t, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_valid", {31'd0, io_dout_output_valid}, 32'd0);
    chk("t6_bits", {24'd0, io_dout_output_bits}, 32'd0);
    chk("t6_busy", {31'd0, io_busy}, 32'd0);
    chk("t6_ready", {31'd0, io_din_input_ready}, 32'd1);
`ifdef SENDU_ISSUE_STATS_EN
    chk("t6_stat_rst", {16'd0, io_stat_bytes}, 32'd0);
`endif
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.push_back(8'h1F);
    push(2'd3, 3'd7, 5'd1);
    drain("t6");
`ifdef SENDU_ISSUE_STATS_EN
    chk("t6_stat", {16'd0, io_stat_bytes}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
